// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump reader and the register_file it walks.
package regfile_dump_pkg;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} dump_state_t;

  localparam int DUMP_DEFAULT_DATA_WIDTH    = 16;
  localparam int DUMP_DEFAULT_ADDRESS_WIDTH = 5;
endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register_file[first..last] (wrapping) through one read port and streams (address, data) beats.
// One READ cycle per beat, so at most one beat every 2 cycles; a stalled beat holds until accepted or aborted.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH    = DUMP_DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DUMP_DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  input  logic                     start_in,
  input  logic                     abort_in,
  input  logic [ADDRESS_WIDTH-1:0] first_register_in,
  input  logic [ADDRESS_WIDTH-1:0] last_register_in,
  output logic [ADDRESS_WIDTH-1:0] read_register_out,
  input  logic [DATA_WIDTH-1:0]    read_data_in,
  output logic                     port_owned_out,
  output logic                     dump_valid_out,
  input  logic                     dump_ready_in,
  output logic [ADDRESS_WIDTH-1:0] dump_address_out,
  output logic [DATA_WIDTH-1:0]    dump_data_out,
  output logic                     dump_last_out,
  output logic                     busy_out,
  output logic                     done_out
);

  dump_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDRESS_WIDTH-1:0]  end_addr_q, end_addr_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      last_q, last_d;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      end_addr_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          cur_addr_d = first_register_in;
          end_addr_d = last_register_in;
          state_d    = READ;
        end
      end
      READ: begin
        addr_d  = cur_addr_q;
        data_d  = read_data_in;
        last_d  = (cur_addr_q == end_addr_q);
        state_d = abort_in ? IDLE : SEND;
      end
      SEND: begin
        // Abort takes priority: a beat accepted in the same cycle is treated as not delivered.
        if (abort_in) begin
          state_d = IDLE;
        end else if (dump_ready_in) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDRESS_WIDTH'(1);
            state_d    = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // addr_q always holds the index last presented in READ, so it doubles as the held read index.
  assign read_register_out = (state_q == READ) ? cur_addr_q : addr_q;
  assign port_owned_out    = (state_q == READ);
  assign dump_valid_out    = (state_q == SEND);
  assign dump_address_out  = addr_q;
  assign dump_data_out     = data_q;
  assign dump_last_out     = (state_q == SEND) && last_q;
  assign busy_out          = (state_q != IDLE);
  assign done_out          = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register_file on its read port.
module tb_regfile_dump_reader;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic [AW-1:0] rd_reg;
    logic [DW-1:0] rd_data;
    logic          port_owned;
    logic          dvld;
    logic          drdy;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddat;
    logic          dlast;
    logic          busy;
    logic          done;

    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rf [32];

    int errors = 0;
    int checks = 0;
    int beat_cnt = 0;
    int done_cnt = 0;

    regfile_dump_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock_in          (clk),
        .reset_n_in        (rst_n),
        .start_in          (start),
        .abort_in          (abort),
        .first_register_in (first_reg),
        .last_register_in  (last_reg),
        .read_register_out (rd_reg),
        .read_data_in      (rd_data),
        .port_owned_out    (port_owned),
        .dump_valid_out    (dvld),
        .dump_ready_in     (drdy),
        .dump_address_out  (daddr),
        .dump_data_out     (ddat),
        .dump_last_out     (dlast),
        .busy_out          (busy),
        .done_out          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_data = rf[rd_reg];

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    // Delivered beats exclude a handshake that coincides with abort.
    always @(posedge clk) begin
        if (dvld && drdy && !abort) beat_cnt <= beat_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; wa = a; wd = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; drdy = 1'b0;
        first_reg = '0; last_reg = '0; we = 1'b0; wa = '0; wd = '0;
        #13;
        checks++;
        if ({dvld, dlast, busy, done, port_owned, rd_reg, daddr, ddat} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0",
                     {dvld, dlast, busy, done, port_owned, rd_reg, daddr, ddat});
        end
        for (int i = 0; i < 32; i++) rf_write(5'(i), 16'h0000);
        #2 rst_n = 1'b1;
        step();
        checks++;
        if ({busy, dvld, done, port_owned} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle got=%b want=0000", {busy, dvld, done, port_owned});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
        int b0, d0;
        rf_write(5'd2, 16'h1111);
        rf_write(5'd3, 16'h2222);
        rf_write(5'd4, 16'h3333);
        drdy = 1'b1; first_reg = 5'd2; last_reg = 5'd4; start = 1'b1;
        b0 = beat_cnt; d0 = done_cnt;
        step();
        start = 1'b0;
        checks++;
        if ({port_owned, rd_reg, dvld} !== {1'b1, 5'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_read0 got=%b want=%b", {port_owned, rd_reg, dvld}, {1'b1, 5'd2, 1'b0});
        end
        step();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if ({dvld, daddr, ddat, dlast} !== {1'b1, 5'(2 + b), exp_d[b], 1'(b == 2)}) begin
                errors++;
                $display("FAIL basic_beat%0d got=%h want=%h", b, {dvld, daddr, ddat, dlast},
                         {1'b1, 5'(2 + b), exp_d[b], 1'(b == 2)});
            end
            step();
            if (b < 2) begin
                checks++;
                if ({port_owned, rd_reg, dvld} !== {1'b1, 5'(3 + b), 1'b0}) begin
                    errors++;
                    $display("FAIL basic_read%0d got=%b want=%b", b + 1, {port_owned, rd_reg, dvld},
                             {1'b1, 5'(3 + b), 1'b0});
                end
                step();
            end
        end
        checks++;
        if ({done, busy, dvld, port_owned} !== 4'b1100) begin
            errors++;
            $display("FAIL basic_done got=%b want=1100", {done, busy, dvld, port_owned});
        end
        step();
        checks++;
        if ({done, busy, rd_reg} !== {2'b00, 5'd4}) begin
            errors++;
            $display("FAIL basic_idle got=%b want=%b", {done, busy, rd_reg}, {2'b00, 5'd4});
        end
        checks++;
        if ((beat_cnt - b0) !== 3 || (done_cnt - d0) !== 1) begin
            errors++;
            $display("FAIL basic_counts got=%0d/%0d want=3/1", beat_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int b0, d0;
        rf_write(5'd7, 16'hBEEF);
        drdy = 1'b0; first_reg = 5'd7; last_reg = 5'd7; start = 1'b1;
        b0 = beat_cnt; d0 = done_cnt;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({dvld, daddr, ddat, dlast} !== {1'b1, 5'd7, 16'hBEEF, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d got=%h want=%h", i, {dvld, daddr, ddat, dlast},
                         {1'b1, 5'd7, 16'hBEEF, 1'b1});
            end
            step();
        end
        drdy = 1'b1;
        checks++;
        if ({dvld, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL bp_still_valid got=%b want=110", {dvld, busy, done});
        end
        step();
        checks++;
        if ({done, dvld} !== 2'b10) begin
            errors++;
            $display("FAIL bp_done got=%b want=10", {done, dvld});
        end
        step();
        step();
        checks++;
        if ((beat_cnt - b0) !== 1 || (done_cnt - d0) !== 1) begin
            errors++;
            $display("FAIL bp_counts got=%0d/%0d want=1/1", beat_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_d [4] = '{16'h3030, 16'h3131, 16'h0000, 16'h0101};
        logic [AW-1:0] exp_a [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        int b0;
        rf_write(5'd30, 16'h3030);
        rf_write(5'd31, 16'h3131);
        rf_write(5'd1, 16'h0101);
        drdy = 1'b1; first_reg = 5'd30; last_reg = 5'd1; start = 1'b1;
        b0 = beat_cnt;
        step();
        start = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            checks++;
            if ({dvld, daddr, ddat, dlast} !== {1'b1, exp_a[b], exp_d[b], 1'(b == 3)}) begin
                errors++;
                $display("FAIL wrap_beat%0d got=%h want=%h", b, {dvld, daddr, ddat, dlast},
                         {1'b1, exp_a[b], exp_d[b], 1'(b == 3)});
            end
            step();
            if (b < 3) step();
        end
        checks++;
        if ({done, (beat_cnt - b0) == 4} !== 2'b11) begin
            errors++;
            $display("FAIL wrap_done got=%b beats=%0d want done=1 beats=4", done, beat_cnt - b0);
        end
        step();
    endtask

    task automatic test_abort();
        int b0, d0;
        rf_write(5'd0, 16'h0000);
        rf_write(5'd5, 16'h0055);
        drdy = 1'b1; first_reg = 5'd0; last_reg = 5'd5; start = 1'b1;
        b0 = beat_cnt; d0 = done_cnt;
        step();
        first_reg = 5'd20; last_reg = 5'd20;
        step();
        checks++;
        if ({dvld, daddr} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL abort_beat0 got=%h want=%h", {dvld, daddr}, {1'b1, 5'd0});
        end
        step();
        checks++;
        if ({port_owned, rd_reg} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL abort_start_ignored got=%h want=%h", {port_owned, rd_reg}, {1'b1, 5'd1});
        end
        step();
        start = 1'b0; abort = 1'b1;
        checks++;
        if ({dvld, daddr, ddat} !== {1'b1, 5'd1, 16'h0101}) begin
            errors++;
            $display("FAIL abort_beat1 got=%h want=%h", {dvld, daddr, ddat}, {1'b1, 5'd1, 16'h0101});
        end
        step();
        abort = 1'b0;
        checks++;
        if ({busy, dvld, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle got=%b want=000", {busy, dvld, done});
        end
        step();
        step();
        checks++;
        if ((beat_cnt - b0) !== 1 || (done_cnt - d0) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_counts got=%0d/%0d busy=%b want=1/0 busy=0",
                     beat_cnt - b0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        drdy = 1'b0; first_reg = 5'd2; last_reg = 5'd4; start = 1'b1;
        d0 = done_cnt;
        step();
        start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dvld, dlast, busy, done, port_owned, rd_reg, daddr, ddat} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {dvld, dlast, busy, done, port_owned, rd_reg, daddr, ddat});
        end
        #1 rst_n = 1'b1;
        drdy = 1'b1;
        step();
        first_reg = 5'd3; last_reg = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({dvld, daddr, ddat, dlast} !== {1'b1, 5'd3, 16'h2222, 1'b1}) begin
            errors++;
            $display("FAIL midreset_beat got=%h want=%h", {dvld, daddr, ddat, dlast},
                     {1'b1, 5'd3, 16'h2222, 1'b1});
        end
        step();
        step();
        checks++;
        if ((done_cnt - d0) !== 1) begin
            errors++;
            $display("FAIL midreset_done got=%0d want=1", done_cnt - d0);
        end
    endtask

    task automatic test_coherence();
        drdy = 1'b1; first_reg = 5'd5; last_reg = 5'd5; start = 1'b1;
        step();
        start = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 16'h00AA;
        step();
        we = 1'b0;
        checks++;
        if ({dvld, daddr, ddat} !== {1'b1, 5'd5, 16'h0055}) begin
            errors++;
            $display("FAIL coh_prewrite got=%h want=%h", {dvld, daddr, ddat}, {1'b1, 5'd5, 16'h0055});
        end
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({dvld, daddr, ddat} !== {1'b1, 5'd5, 16'h00AA}) begin
            errors++;
            $display("FAIL coh_postwrite got=%h want=%h", {dvld, daddr, ddat}, {1'b1, 5'd5, 16'h00AA});
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_coherence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
